user_data_writer: RTL

- Frame generator and buffer on the FPGA-to-PC data path. It produces the user-data stream that control_interface drains through its DATA_FIFO port.
- On a START pulse (driven from a PULSE_REG bit), it writes one frame into an internal single-clock first-word-fall-through (FWFT) FIFO: header, LENGTH payload words, trailer.
- It is the writer/producer end of the DATA_FIFO_Q / DATA_FIFO_EMPTY / DATA_FIFO_RDREQ read interface.

---
 rtl/user_data_writer_pkg.sv | 17 +
 rtl/user_data_writer_if.sv | 22 ++
 rtl/sync_fwft_fifo.sv | 68 ++++++
 rtl/user_data_writer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/user_data_writer_pkg.sv
// Shared types and constants for the user-data frame writer.
// Pure definitions; no timing or backpressure of its own.
package user_data_pkg;

  localparam int DATA_W = 32;

  localparam logic [15:0] HDR_MARK_DEF = 16'hA5A5;
  localparam logic [15:0] TRL_MARK_DEF = 16'h5A5A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_TRL  = 2'd3
  } state_e;

endpackage

// File: rtl/user_data_writer_if.sv
// DATA_FIFO read port between the frame writer (master) and its consumer (slave).
// FWFT: Q is valid whenever EMPTY is low; RDREQ pops the head word at the clock edge.
interface user_data_writer_if;
  import user_data_pkg::*;

  logic [DATA_W-1:0] DATA_FIFO_Q;
  logic              DATA_FIFO_EMPTY;
  logic              DATA_FIFO_RDREQ;

  modport master (
    output DATA_FIFO_Q,
    output DATA_FIFO_EMPTY,
    input  DATA_FIFO_RDREQ
  );

  modport slave (
    input  DATA_FIFO_Q,
    input  DATA_FIFO_EMPTY,
    output DATA_FIFO_RDREQ
  );

endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// Write at edge N is visible the cycle after; full uses registered count only.
module sync_fwft_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic [DEPTH_LOG2:0]   kept;
  logic                  do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != FULL_CNT);
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_wr);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_rd);
    kept     = count_q - (DEPTH_LOG2 + 1)'(do_rd);
    count_d  = kept + (DEPTH_LOG2 + 1)'(do_wr);
    dout_d   = dout_q;
    // Head word comes straight from din when the write lands in an otherwise empty FIFO.
    if (kept == '0) begin
      if (do_wr) dout_d = din;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

endmodule

// File: rtl/user_data_writer.sv
// Frame generator: header, LENGTH payload words, trailer into an FWFT FIFO, one word/cycle.
// START accepted only when idle; a full FIFO stalls the FSM without dropping words.
module user_data_writer
  import user_data_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [15:0] HDR_MARK   = HDR_MARK_DEF,
  parameter logic [15:0] TRL_MARK   = TRL_MARK_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [15:0]             LENGTH,
  input  logic                    MODE,
  input  logic [DATA_W-1:0]       SEED,
  user_data_writer_if.master      data_fifo,
  output logic                    BUSY,
  output logic [15:0]             FRAME_CNT,
  output logic [DEPTH_LOG2:0]     FIFO_COUNT
);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] pay_val_q, pay_val_d;
  logic [15:0]       pay_cnt_q, pay_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              wr_vld;
  logic [DATA_W-1:0] wr_dat;
  logic              fifo_full;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    pay_val_d   = pay_val_q;
    pay_cnt_d   = pay_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wr_vld      = 1'b0;
    wr_dat      = '0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          len_d     = LENGTH;
          mode_d    = MODE;
          seed_d    = SEED;
          pay_val_d = SEED;
          pay_cnt_d = '0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        wr_vld = 1'b1;
        wr_dat = {HDR_MARK, len_q};
        if (!fifo_full) state_d = (len_q != '0) ? ST_PAY : ST_TRL;
      end
      ST_PAY: begin
        wr_vld = 1'b1;
        wr_dat = mode_q ? seed_q : pay_val_q;
        if (!fifo_full) begin
          pay_val_d = pay_val_q + 32'd1;
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (pay_cnt_q == len_q - 16'd1) state_d = ST_TRL;
        end
      end
      ST_TRL: begin
        wr_vld = 1'b1;
        // Trailer carries the count of frames completed before this one.
        wr_dat = {TRL_MARK, frame_cnt_q};
        if (!fifo_full) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mode_q      <= 1'b0;
      seed_q      <= '0;
      pay_val_q   <= '0;
      pay_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      pay_val_q   <= pay_val_d;
      pay_cnt_q   <= pay_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  sync_fwft_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .wr_en (wr_vld),
    .din   (wr_dat),
    .full  (fifo_full),
    .rd_en (data_fifo.DATA_FIFO_RDREQ),
    .dout  (data_fifo.DATA_FIFO_Q),
    .empty (data_fifo.DATA_FIFO_EMPTY),
    .count (FIFO_COUNT)
  );

  assign BUSY      = (state_q != ST_IDLE);
  assign FRAME_CNT = frame_cnt_q;

endmodule
